// File: rtl/a_format_decoder_pkg.sv
// Shared constants and types for the PowerPC A-form decoder.
// Instruction bit k (big-endian, bit 0 = MSB) lives at vector index 31-k.
package a_format_decoder_pkg;

  localparam int ADDR_W    = 64;
  localparam int INST_W    = 32;
  localparam int PID_W     = 20;
  localparam int TID_W     = 16;
  localparam int MAJ_ID_W  = 64;
  localparam int MIN_ID_W  = 7;
  localparam int OPCODE_W  = 12;
  localparam int PRIM_OP_W = 6;
  localparam int REG_W     = 5;
  localparam int RW_W      = 2;
  localparam int FU_W      = 3;
  localparam int FMT_W     = 26;
  localparam int BODY_W    = 21;

  localparam logic [FU_W-1:0] FX_UNIT_ID = 3'd0;
  localparam logic [FU_W-1:0] FP_UNIT_ID = 3'd1;

  localparam logic [RW_W-1:0] REG_NONE  = 2'b00;
  localparam logic [RW_W-1:0] REG_READ  = 2'b10;
  localparam logic [RW_W-1:0] REG_WRITE = 2'b01;

  localparam logic [FMT_W-1:0] FMT_A = 26'd2;

  localparam logic [PRIM_OP_W-1:0] OP_31 = 6'd31;
  localparam logic [PRIM_OP_W-1:0] OP_59 = 6'd59;
  localparam logic [PRIM_OP_W-1:0] OP_63 = 6'd63;

  localparam logic [REG_W-1:0] XO_ISEL    = 5'd15;
  localparam logic [REG_W-1:0] XO_FDIV    = 5'd18;
  localparam logic [REG_W-1:0] XO_FSUB    = 5'd20;
  localparam logic [REG_W-1:0] XO_FADD    = 5'd21;
  localparam logic [REG_W-1:0] XO_FSQRT   = 5'd22;
  localparam logic [REG_W-1:0] XO_FSEL    = 5'd23;
  localparam logic [REG_W-1:0] XO_FRE     = 5'd24;
  localparam logic [REG_W-1:0] XO_FMUL    = 5'd25;
  localparam logic [REG_W-1:0] XO_FRSQRTE = 5'd26;
  localparam logic [REG_W-1:0] XO_FMSUB   = 5'd28;
  localparam logic [REG_W-1:0] XO_FMADD   = 5'd29;
  localparam logic [REG_W-1:0] XO_FNMSUB  = 5'd30;
  localparam logic [REG_W-1:0] XO_FNMADD  = 5'd31;

  // is_reg[3] belongs to op1, is_reg[0] to op4
  typedef struct packed {
    logic            valid;
    logic [FU_W-1:0] unit;
    logic [RW_W-1:0] rw1;
    logic [RW_W-1:0] rw2;
    logic [RW_W-1:0] rw3;
    logic [RW_W-1:0] rw4;
    logic [3:0]      is_reg;
  } xo_info_t;

endpackage

// File: rtl/a_format_decoder_if.sv
// Decoder bus: instruction-in side plus registered decode-out side.
interface a_format_decoder_if;
  import a_format_decoder_pkg::*;

  logic                 enable_i;
  logic                 stall_i;
  logic [FMT_W-1:0]     instFormat_i;
  logic [PRIM_OP_W-1:0] instructionOpcode_i;
  logic [INST_W-1:0]    instruction_i;
  logic [ADDR_W-1:0]    instructionAddress_i;
  logic                 is64Bit_i;
  logic [PID_W-1:0]     instructionPid_i;
  logic [TID_W-1:0]     instructionTid_i;
  logic [MAJ_ID_W-1:0]  instructionMajId_i;

  logic                 enable_o;
  logic [OPCODE_W-1:0]  opcode_o;
  logic [FU_W-1:0]      functionalUnitType_o;
  logic [ADDR_W-1:0]    instructionAddress_o;
  logic                 is64Bit_o;
  logic [PID_W-1:0]     instPid_o;
  logic [TID_W-1:0]     instTid_o;
  logic [MAJ_ID_W-1:0]  instMajId_o;
  logic [MIN_ID_W-1:0]  instMinId_o;
  logic [RW_W-1:0]      op1rw_o;
  logic [RW_W-1:0]      op2rw_o;
  logic [RW_W-1:0]      op3rw_o;
  logic [RW_W-1:0]      op4rw_o;
  logic                 op1IsReg_o;
  logic                 op2IsReg_o;
  logic                 op3IsReg_o;
  logic                 op4IsReg_o;
  logic [BODY_W-1:0]    instructionBody_o;

  modport slave (
    input  enable_i, stall_i, instFormat_i, instructionOpcode_i, instruction_i,
           instructionAddress_i, is64Bit_i, instructionPid_i, instructionTid_i,
           instructionMajId_i,
    output enable_o, opcode_o, functionalUnitType_o, instructionAddress_o, is64Bit_o,
           instPid_o, instTid_o, instMajId_o, instMinId_o, op1rw_o, op2rw_o, op3rw_o,
           op4rw_o, op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, instructionBody_o
  );

  modport master (
    output enable_i, stall_i, instFormat_i, instructionOpcode_i, instruction_i,
           instructionAddress_i, is64Bit_i, instructionPid_i, instructionTid_i,
           instructionMajId_i,
    input  enable_o, opcode_o, functionalUnitType_o, instructionAddress_o, is64Bit_o,
           instPid_o, instTid_o, instMajId_o, instMinId_o, op1rw_o, op2rw_o, op3rw_o,
           op4rw_o, op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, instructionBody_o
  );

endinterface

// File: rtl/a_form_xo_lookup.sv
// Combinational {primary opcode, XO} -> {valid, unit, operand usage} table.
// FP entries (opcodes 59/63) exist only when AFORMAT_FP_EN is defined.
module a_form_xo_lookup
  import a_format_decoder_pkg::*;
(
  input  logic [PRIM_OP_W-1:0] i_prim_op,
  input  logic [REG_W-1:0]     i_xo,
  output xo_info_t             o_info
);

`ifdef AFORMAT_FP_EN
  logic       w_fp_valid;
  logic [3:0] w_fp_use;

  // op1 (FRT) is always written; the mask says which of FRA/FRB/FRC are read
  always_comb begin
    w_fp_valid = 1'b1;
    w_fp_use   = 4'b0000;
    case (i_xo)
      XO_FDIV, XO_FSUB, XO_FADD:      w_fp_use = 4'b1110;
      XO_FSQRT, XO_FRE, XO_FRSQRTE:   w_fp_use = 4'b1010;
      XO_FMUL:                        w_fp_use = 4'b1101;
      XO_FMSUB, XO_FMADD,
      XO_FNMSUB, XO_FNMADD:           w_fp_use = 4'b1111;
      XO_FSEL: begin
        w_fp_use   = 4'b1111;
        w_fp_valid = (i_prim_op == OP_63);
      end
      default:                        w_fp_valid = 1'b0;
    endcase
  end
`endif

  always_comb begin
    o_info = '0;
    if (i_prim_op == OP_31 && i_xo == XO_ISEL) begin
      o_info.valid  = 1'b1;
      o_info.unit   = FX_UNIT_ID;
      o_info.rw1    = REG_WRITE;
      o_info.rw2    = REG_READ;
      o_info.rw3    = REG_READ;
      // BC names a CR bit, so it is read but is not a GPR
      o_info.rw4    = REG_READ;
      o_info.is_reg = 4'b1110;
`ifdef AFORMAT_FP_EN
    end else if ((i_prim_op == OP_59 || i_prim_op == OP_63) && w_fp_valid) begin
      o_info.valid  = 1'b1;
      o_info.unit   = FP_UNIT_ID;
      o_info.rw1    = REG_WRITE;
      o_info.rw2    = w_fp_use[2] ? REG_READ : REG_NONE;
      o_info.rw3    = w_fp_use[1] ? REG_READ : REG_NONE;
      o_info.rw4    = w_fp_use[0] ? REG_READ : REG_NONE;
      o_info.is_reg = w_fp_use;
`endif
    end
  end

endmodule

// File: rtl/a_format_decoder.sv
// A-form decode stage: one register stage behind the XO lookup table.
// Build with AFORMAT_FP_EN defined to decode the FP A-form instructions too.
module a_format_decoder
  import a_format_decoder_pkg::*;
(
  input  logic                clock_i,
  input  logic                reset_i,
  a_format_decoder_if.slave   dec_if
);

  logic [REG_W-1:0]    w_xo;
  xo_info_t            w_info;

  logic                r_enable;
  logic [OPCODE_W-1:0] r_opcode;
  logic [FU_W-1:0]     r_unit;
  logic [RW_W-1:0]     r_rw1, r_rw2, r_rw3, r_rw4;
  logic [3:0]          r_is_reg;
  logic [BODY_W-1:0]   r_body;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_is64;
  logic [PID_W-1:0]    r_pid;
  logic [TID_W-1:0]    r_tid;
  logic [MAJ_ID_W-1:0] r_maj_id;

  // Big-endian bits 26..30 map to indices 5..1
  assign w_xo = dec_if.instruction_i[5:1];

  a_form_xo_lookup u_lookup (
    .i_prim_op (dec_if.instructionOpcode_i),
    .i_xo      (w_xo),
    .o_info    (w_info)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_enable <= 1'b0;
      r_opcode <= '0;
      r_unit   <= '0;
      r_rw1    <= '0;
      r_rw2    <= '0;
      r_rw3    <= '0;
      r_rw4    <= '0;
      r_is_reg <= '0;
      r_body   <= '0;
      r_addr   <= '0;
      r_is64   <= 1'b0;
      r_pid    <= '0;
      r_tid    <= '0;
      r_maj_id <= '0;
    end else if (!dec_if.stall_i) begin
      r_enable <= dec_if.enable_i && (dec_if.instFormat_i == FMT_A) && w_info.valid;
      r_opcode <= {dec_if.instructionOpcode_i, w_xo, 1'b0};
      r_unit   <= w_info.unit;
      r_rw1    <= w_info.rw1;
      r_rw2    <= w_info.rw2;
      r_rw3    <= w_info.rw3;
      r_rw4    <= w_info.rw4;
      r_is_reg <= w_info.is_reg;
      // Bits 6..25 (operand fields) followed by Rc
      r_body   <= {dec_if.instruction_i[25:6], dec_if.instruction_i[0]};
      r_addr   <= dec_if.instructionAddress_i;
      r_is64   <= dec_if.is64Bit_i;
      r_pid    <= dec_if.instructionPid_i;
      r_tid    <= dec_if.instructionTid_i;
      r_maj_id <= dec_if.instructionMajId_i;
    end
  end

  assign dec_if.enable_o             = r_enable;
  assign dec_if.opcode_o             = r_opcode;
  assign dec_if.functionalUnitType_o = r_unit;
  assign dec_if.op1rw_o              = r_rw1;
  assign dec_if.op2rw_o              = r_rw2;
  assign dec_if.op3rw_o              = r_rw3;
  assign dec_if.op4rw_o              = r_rw4;
  assign dec_if.op1IsReg_o           = r_is_reg[3];
  assign dec_if.op2IsReg_o           = r_is_reg[2];
  assign dec_if.op3IsReg_o           = r_is_reg[1];
  assign dec_if.op4IsReg_o           = r_is_reg[0];
  assign dec_if.instructionBody_o    = r_body;
  assign dec_if.instructionAddress_o = r_addr;
  assign dec_if.is64Bit_o            = r_is64;
  assign dec_if.instPid_o            = r_pid;
  assign dec_if.instTid_o            = r_tid;
  assign dec_if.instMajId_o          = r_maj_id;
  assign dec_if.instMinId_o          = '0;

endmodule

// File: tb/tb_a_format_decoder.sv
// Directed self-checking bench for a_format_decoder (honours AFORMAT_FP_EN).
module tb_a_format_decoder;
  import a_format_decoder_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   en_count;

  always #5 clk = ~clk;

  a_format_decoder_if dif ();

  a_format_decoder dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .dec_if  (dif)
  );

  localparam logic [20:0] BODY_RC0 = {5'b01110, 5'b10101, 5'b01010, 5'b10001, 1'b0};
  localparam logic [20:0] BODY_RC1 = {5'b01110, 5'b10101, 5'b01010, 5'b10001, 1'b1};

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] xo, input logic rc);
    return {op, 5'b01110, 5'b10101, 5'b01010, 5'b10001, xo, rc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic st, input logic [25:0] fmt,
                       input logic [5:0] op, input logic [4:0] xo, input logic rc);
    dif.enable_i            = en;
    dif.stall_i             = st;
    dif.instFormat_i        = fmt;
    dif.instructionOpcode_i = op;
    dif.instruction_i       = mk(op, xo, rc);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rw(input string tag, input logic [1:0] r1, input logic [1:0] r2,
                        input logic [1:0] r3, input logic [1:0] r4, input logic [3:0] isr);
    chk({tag, "_op1rw"}, 64'(dif.op1rw_o), 64'(r1));
    chk({tag, "_op2rw"}, 64'(dif.op2rw_o), 64'(r2));
    chk({tag, "_op3rw"}, 64'(dif.op3rw_o), 64'(r3));
    chk({tag, "_op4rw"}, 64'(dif.op4rw_o), 64'(r4));
    chk({tag, "_isreg"}, 64'({dif.op1IsReg_o, dif.op2IsReg_o, dif.op3IsReg_o, dif.op4IsReg_o}),
        64'(isr));
  endtask

  initial begin
    drive(1'b0, 1'b0, 26'd0, 6'd0, 5'd0, 1'b0);
    dif.instructionAddress_i = '0;
    dif.is64Bit_i            = 1'b0;
    dif.instructionPid_i     = '0;
    dif.instructionTid_i     = '0;
    dif.instructionMajId_i   = '0;

    // Reset asserted asynchronously before the first clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_enable", 64'(dif.enable_o), 64'd0);
    chk("rst_opcode", 64'(dif.opcode_o), 64'd0);
    chk("rst_unit",   64'(dif.functionalUnitType_o), 64'd0);
    chk("rst_body",   64'(dif.instructionBody_o), 64'd0);
    chk("rst_addr",   dif.instructionAddress_o, 64'd0);
    chk("rst_minid",  64'(dif.instMinId_o), 64'd0);
    chk_rw("rst", 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
    tick;
    tick;
    rst_n = 1'b1;

    // isel
    dif.instructionAddress_i = 64'h0123_4567_89AB_CDE0;
    dif.is64Bit_i            = 1'b1;
    dif.instructionPid_i     = 20'hABCDE;
    dif.instructionTid_i     = 16'h1234;
    dif.instructionMajId_i   = 64'hFEDC_BA98_7654_3210;
    drive(1'b1, 1'b0, FMT_A, 6'd31, 5'd15, 1'b0);
    tick;
    chk("isel_enable", 64'(dif.enable_o), 64'd1);
    chk("isel_opcode", 64'(dif.opcode_o), 64'h7DE);
    chk("isel_unit",   64'(dif.functionalUnitType_o), 64'd0);
    chk_rw("isel", 2'b01, 2'b10, 2'b10, 2'b10, 4'b1110);
    chk("isel_body",   64'(dif.instructionBody_o), 64'(BODY_RC0));
    chk("isel_addr",   dif.instructionAddress_o, 64'h0123_4567_89AB_CDE0);
    chk("isel_is64",   64'(dif.is64Bit_o), 64'd1);
    chk("isel_pid",    64'(dif.instPid_o), 64'hABCDE);
    chk("isel_tid",    64'(dif.instTid_o), 64'h1234);
    chk("isel_majid",  dif.instMajId_o, 64'hFEDC_BA98_7654_3210);
    chk("isel_minid",  64'(dif.instMinId_o), 64'd0);

    // fmadd with Rc = 1
    drive(1'b1, 1'b0, FMT_A, 6'd63, 5'd29, 1'b1);
    tick;
`ifdef AFORMAT_FP_EN
    chk("fmadd_enable", 64'(dif.enable_o), 64'd1);
    chk("fmadd_opcode", 64'(dif.opcode_o), 64'hFFA);
    chk("fmadd_unit",   64'(dif.functionalUnitType_o), 64'd1);
    chk_rw("fmadd", 2'b01, 2'b10, 2'b10, 2'b10, 4'b1111);
    chk("fmadd_body",   64'(dif.instructionBody_o), 64'(BODY_RC1));
`else
    chk("fmadd_enable", 64'(dif.enable_o), 64'd0);
`endif

    // fsqrts
    drive(1'b1, 1'b0, FMT_A, 6'd59, 5'd22, 1'b0);
    tick;
`ifdef AFORMAT_FP_EN
    chk("fsqrts_enable", 64'(dif.enable_o), 64'd1);
    chk("fsqrts_opcode", 64'(dif.opcode_o), 64'hEEC);
    chk_rw("fsqrts", 2'b01, 2'b00, 2'b10, 2'b00, 4'b1010);
`else
    chk("fsqrts_enable", 64'(dif.enable_o), 64'd0);
`endif

    // fmul: FRA and FRC read, FRB unused
    drive(1'b1, 1'b0, FMT_A, 6'd63, 5'd25, 1'b0);
    tick;
`ifdef AFORMAT_FP_EN
    chk("fmul_enable", 64'(dif.enable_o), 64'd1);
    chk_rw("fmul", 2'b01, 2'b10, 2'b00, 2'b10, 4'b1101);
`else
    chk("fmul_enable", 64'(dif.enable_o), 64'd0);
`endif

    // fsel exists only under opcode 63
    drive(1'b1, 1'b0, FMT_A, 6'd59, 5'd23, 1'b0);
    tick;
    chk("fsel59_enable", 64'(dif.enable_o), 64'd0);

    // isel but classifier says another format
    drive(1'b1, 1'b0, 26'd3, 6'd31, 5'd15, 1'b0);
    tick;
    chk("wrongfmt_enable", 64'(dif.enable_o), 64'd0);

    // isel with enable low
    drive(1'b0, 1'b0, FMT_A, 6'd31, 5'd15, 1'b0);
    tick;
    chk("en0_enable", 64'(dif.enable_o), 64'd0);

    // Stall holds a valid isel result while new inputs arrive
    drive(1'b1, 1'b0, FMT_A, 6'd31, 5'd15, 1'b0);
    tick;
    chk("prestall_enable", 64'(dif.enable_o), 64'd1);
    dif.instructionAddress_i = 64'h0000_0000_0000_1000;
    drive(1'b1, 1'b1, FMT_A, 6'd63, 5'd29, 1'b1);
    tick;
    chk("stall1_opcode", 64'(dif.opcode_o), 64'h7DE);
    chk("stall1_op4isreg", 64'(dif.op4IsReg_o), 64'd0);
    chk("stall1_addr", dif.instructionAddress_o, 64'h0123_4567_89AB_CDE0);
    drive(1'b0, 1'b1, FMT_A, 6'd63, 5'd29, 1'b1);
    tick;
    chk("stall2_enable", 64'(dif.enable_o), 64'd1);
    chk("stall2_body", 64'(dif.instructionBody_o), 64'(BODY_RC0));
    drive(1'b1, 1'b0, FMT_A, 6'd63, 5'd29, 1'b1);
    tick;
    chk("unstall_addr", dif.instructionAddress_o, 64'h0000_0000_0000_1000);
`ifdef AFORMAT_FP_EN
    chk("unstall_enable", 64'(dif.enable_o), 64'd1);
    chk("unstall_opcode", 64'(dif.opcode_o), 64'hFFA);
`else
    chk("unstall_enable", 64'(dif.enable_o), 64'd0);
`endif

    // Full opcode x XO sweep, back to back
    en_count = 0;
    for (int op = 0; op < 64; op++) begin
      for (int xo = 0; xo < 32; xo++) begin
        drive(1'b1, 1'b0, FMT_A, 6'(op), 5'(xo), 1'b0);
        tick;
        if (dif.enable_o === 1'b1) en_count++;
      end
    end
`ifdef AFORMAT_FP_EN
    chk("sweep_count", 64'(en_count), 64'd24);
`else
    chk("sweep_count", 64'(en_count), 64'd1);
`endif

    // Reset mid-stream clears outputs without a clock edge
    drive(1'b1, 1'b0, FMT_A, 6'd31, 5'd15, 1'b0);
    tick;
    chk("premid_enable", 64'(dif.enable_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_enable", 64'(dif.enable_o), 64'd0);
    chk("midrst_opcode", 64'(dif.opcode_o), 64'd0);
    chk("midrst_addr",   dif.instructionAddress_o, 64'd0);
    chk("midrst_majid",  dif.instMajId_o, 64'd0);
    chk_rw("midrst", 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
    tick;
    chk("rsthold_enable", 64'(dif.enable_o), 64'd0);
    rst_n = 1'b1;
    tick;
    chk("recover_enable", 64'(dif.enable_o), 64'd1);
    chk("recover_opcode", 64'(dif.opcode_o), 64'h7DE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
